// File: rtl/siso_arb_ctrl.sv
// Two-requester round-robin serializer: grants one parallel word at a time
// and shifts it out LSB-first on a single serial lane, with a hold input.
module siso_arb_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             hold,
  output logic             sout,
  output logic             sout_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             prio;
  logic             idle;

  assign idle = (state == S_IDLE);

  // prio only matters when both request; a lone requester always wins
  always_comb begin
    req0_ready = idle & req0_valid & (~req1_valid | ~prio);
    req1_ready = idle & req1_valid & (~req0_valid |  prio);
  end

  assign sout       = (state == S_SHIFT) & shreg[0];
  assign sout_valid = (state == S_SHIFT) & ~hold;
  assign busy       = (state == S_SHIFT) | (state == S_DONE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
      prio  <= 1'b0;
      owner <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_ready) begin
            shreg <= req0_data;
            owner <= 1'b0;
            cnt   <= '0;
            state <= S_SHIFT;
          end else if (req1_ready) begin
            shreg <= req1_data;
            owner <= 1'b1;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!hold) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          prio  <= ~owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_arb_ctrl.sv
// Scoreboard bench for siso_arb_ctrl: expected serial bits are queued at
// each grant and popped by a monitor whenever sout_valid is seen.
module tb_siso_arb_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, sout, sout_valid, owner, busy, done;

  siso_arb_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .sout(sout), .sout_valid(sout_valid), .owner(owner),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; logic own; logic last; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic pend_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // serial stream, done timing and handshake sanity every cycle
  always @(negedge clk) begin
    exp_t e;
    chk("done", done, pend_done);
    pend_done = 1'b0;
    chk("ready_excl", req0_ready & req1_ready, 0);
    chk("ready_busy", (req0_ready | req1_ready) & busy, 0);
    if (sout_valid) begin
      if (sb.size() == 0) chk("sout_spurious", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sout", sout, e.b);
        chk("owner", owner, e.own);
        pend_done = e.last;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input logic idx, input logic [W-1:0] d, output int t);
    logic [W-1:0] v;
    bit got;
    exp_t e;
    got = 0; t = -1; v = d;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req0_ready | req1_ready) begin
        chk("grant_idx", req1_ready, idx);
        for (int k = 0; k < W; k++) begin
          e.b = v[k]; e.own = idx; e.last = (k == W - 1);
          sb.push_back(e);
        end
        t = cyc; got = 1;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int t);
    bit got;
    got = 0; t = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin t = cyc; got = 1; end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_outs"}, {sout, sout_valid, busy, done, owner, req0_ready, req1_ready}, 0);
  endtask

  task automatic do_reset();
    step(); resetn = 1'b0; req0_valid = 0; req1_valid = 0; hold = 0;
    step(); step();
    @(negedge clk); check_idle_zero("reset");
    sb.delete(); pend_done = 1'b0;
    step(); resetn = 1'b1;
  endtask

  task automatic send(input logic v0, input logic v1, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input logic exp_idx);
    int t, dc;
    step(); req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    wait_accept(exp_idx, exp_idx ? d1 : d0, t);
    step(); req0_valid = 0; req1_valid = 0;
    wait_done(dc);
    chk("send_done_lat", dc - t, W + 1);
  endtask

  initial begin
    int t0, t1, t2, dc, tr;

    do_reset();

    // single word, no contention
    req0_valid = 1; req0_data = 4'b1011;
    wait_accept(0, 4'b1011, t0);
    step(); req0_valid = 0;
    chk("t1_ready_after", req0_ready, 0);
    wait_done(dc);
    chk("t1_done_cyc", dc - t0, 5);

    // simultaneous requests after reset: req0 first, req1 at T+6
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 4'hA; req1_data = 4'h5;
    wait_accept(0, 4'hA, t0);
    step(); req0_valid = 0;
    wait_accept(1, 4'h5, t1);
    chk("t2_second_accept", t1 - t0, 6);
    step(); req1_valid = 0;
    wait_done(dc);

    // tie-break alternates with whoever was served last
    send(1, 0, 4'h7, 4'h0, 0);
    send(0, 1, 4'h0, 4'hC, 1);
    send(1, 1, 4'h2, 4'hD, 0);
    send(1, 1, 4'h6, 4'h9, 1);

    // hold for two cycles after bit 1
    step(); req0_valid = 1; req0_data = 4'b0110;
    wait_accept(0, 4'b0110, t0);
    step(); req0_valid = 0;
    step();
    step(); hold = 1;
    @(negedge clk); chk("hold_sout_a", {sout, sout_valid}, 2'b10);
    step();
    @(negedge clk); chk("hold_sout_b", {sout, sout_valid}, 2'b10);
    step(); hold = 0;
    wait_done(dc);
    chk("hold_done_cyc", dc - t0, 7);

    // reset mid-shift on a req1 word, then immediate re-accept
    step(); req1_valid = 1; req1_data = 4'b1001;
    wait_accept(1, 4'b1001, t0);
    step(); req1_valid = 0;
    step(); resetn = 0;
    step();
    @(negedge clk); check_idle_zero("midrst");
    sb.delete();
    step(); resetn = 1; req0_valid = 1; req0_data = 4'hC; tr = cyc;
    wait_accept(0, 4'hC, t1);
    chk("midrst_reaccept", t1 - tr, 0);
    step(); req0_valid = 0;
    wait_done(dc);

    // back-to-back lone requester
    step(); req0_valid = 1; req0_data = 4'h3;
    wait_accept(0, 4'h3, t0);
    step(); req0_data = 4'h9;
    wait_accept(0, 4'h9, t1);
    step(); req0_data = 4'hE;
    wait_accept(0, 4'hE, t2);
    step(); req0_valid = 0;
    chk("b2b_gap1", t1 - t0, 6);
    chk("b2b_gap2", t2 - t1, 6);
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
